// File: rtl/freq_seq_pkg.sv
// Shared types and defaults for the frequency step sequencer.
// Frequency words carry 4 fractional bits below the integer part.
package freq_seq_pkg;

    localparam int DEF_STEPS  = 8;
    localparam int DEF_FREQ_W = 20;
    localparam int DEF_TICK_W = 24;
    localparam int FREQ_REST  = 0;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        PAUSE
    } seq_state_e;

endpackage

// File: rtl/freq_step_bank.sv
// Bank of step frequency registers with write decode and a read mux.
module freq_step_bank
    import freq_seq_pkg::*;
#(
    parameter int STEPS  = DEF_STEPS,
    parameter int FREQ_W = DEF_FREQ_W,
    parameter int IDX_W  = $clog2(STEPS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_addr,
    input  logic [FREQ_W-1:0] i_wr_freq,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [FREQ_W-1:0] o_rd_freq
);

    logic [FREQ_W-1:0] r_bank [STEPS];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < STEPS; i++) begin
                r_bank[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_bank[i_wr_addr] <= i_wr_freq;
        end
    end

    assign o_rd_freq = r_bank[i_rd_addr];

endmodule

// File: rtl/freq_seq_controller.sv
// Step sequencer: plays the step bank in order at a programmable step
// length, presenting frequency, gate and a per-step pulse downstream.
module freq_seq_controller
    import freq_seq_pkg::*;
#(
    parameter int STEPS  = DEF_STEPS,
    parameter int FREQ_W = DEF_FREQ_W,
    parameter int TICK_W = DEF_TICK_W,
    parameter int IDX_W  = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [FREQ_W-1:0] wr_freq,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [IDX_W-1:0]  last_step,
    input  logic [TICK_W-1:0] step_len,
    input  logic [TICK_W-1:0] gate_len,
    output logic [FREQ_W-1:0] freq_out,
    output logic              gate,
    output logic [IDX_W-1:0]  step_idx,
    output logic              playing,
    output logic              step_pulse
);

    seq_state_e        r_state;
    seq_state_e        w_state_nx;
    logic [TICK_W-1:0] r_tick;
    logic [TICK_W-1:0] w_tick_nx;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nx;
    logic              r_pulse;
    logic              w_pulse_nx;
    logic [TICK_W-1:0] w_len_m1;
    logic              w_wrap;
    logic [FREQ_W-1:0] w_rd_freq;

    freq_step_bank #(
        .STEPS  (STEPS),
        .FREQ_W (FREQ_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_freq (wr_freq),
        .i_rd_addr (r_idx),
        .o_rd_freq (w_rd_freq)
    );

    // A step length of 0 behaves as 1; >= keeps a shortened step from overrunning.
    assign w_len_m1 = (step_len == '0) ? '0 : step_len - TICK_W'(1);
    assign w_wrap   = (r_tick >= w_len_m1);

    always_comb begin
        w_state_nx = r_state;
        w_tick_nx  = r_tick;
        w_idx_nx   = r_idx;
        w_pulse_nx = 1'b0;
        if (stop) begin
            w_state_nx = IDLE;
            w_tick_nx  = '0;
            w_idx_nx   = '0;
        end else if (start) begin
            w_state_nx = PLAY;
            w_tick_nx  = '0;
            w_idx_nx   = '0;
            w_pulse_nx = 1'b1;
        end else begin
            case (r_state)
                PLAY: begin
                    if (pause) begin
                        w_state_nx = PAUSE;
                    end else if (w_wrap) begin
                        w_tick_nx  = '0;
                        w_idx_nx   = (r_idx >= last_step) ? '0 : r_idx + IDX_W'(1);
                        w_pulse_nx = 1'b1;
                    end else begin
                        w_tick_nx = r_tick + TICK_W'(1);
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        w_state_nx = PLAY;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_idx   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_tick  <= w_tick_nx;
            r_idx   <= w_idx_nx;
            r_pulse <= w_pulse_nx;
        end
    end

    assign freq_out   = (r_state == IDLE) ? '0 : w_rd_freq;
    assign gate       = (r_state == PLAY) && (r_tick < gate_len)
                        && (w_rd_freq != FREQ_W'(FREQ_REST));
    assign step_idx   = r_idx;
    assign playing    = (r_state != IDLE);
    assign step_pulse = r_pulse;

endmodule

// File: tb/tb_freq_seq_controller.sv
// Bench for freq_seq_controller: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_freq_seq_controller;

    localparam int STEPS  = 8;
    localparam int FREQ_W = 20;
    localparam int TICK_W = 24;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [IDX_W-1:0]  wr_addr = '0;
    logic [FREQ_W-1:0] wr_freq = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              pause = 1'b0;
    logic [IDX_W-1:0]  last_step = '0;
    logic [TICK_W-1:0] step_len = '0;
    logic [TICK_W-1:0] gate_len = '0;
    logic [FREQ_W-1:0] freq_out;
    logic              gate;
    logic [IDX_W-1:0]  step_idx;
    logic              playing;
    logic              step_pulse;

    always #5 clk = ~clk;

    freq_seq_controller dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_freq    (wr_freq),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .last_step  (last_step),
        .step_len   (step_len),
        .gate_len   (gate_len),
        .freq_out   (freq_out),
        .gate       (gate),
        .step_idx   (step_idx),
        .playing    (playing),
        .step_pulse (step_pulse)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: mode 0 = idle, 1 = playing, 2 = paused.
    int          m_mode;
    int          m_tick;
    int          m_idx;
    bit          m_pulse;
    int unsigned m_bank [STEPS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        m_mode  = 0;
        m_tick  = 0;
        m_idx   = 0;
        m_pulse = 1'b0;
        for (int i = 0; i < STEPS; i++) m_bank[i] = 0;
    endtask

    task automatic m_update();
        int len;
        if (reset) begin
            m_reset();
            return;
        end
        len = (step_len == 0) ? 1 : int'(step_len);
        m_pulse = 1'b0;
        if (stop) begin
            m_mode = 0;
            m_tick = 0;
            m_idx  = 0;
        end else if (start) begin
            m_mode  = 1;
            m_tick  = 0;
            m_idx   = 0;
            m_pulse = 1'b1;
        end else if (m_mode == 1) begin
            if (pause) begin
                m_mode = 2;
            end else if (m_tick == len - 1) begin
                m_tick  = 0;
                m_idx   = (m_idx >= int'(last_step)) ? 0 : m_idx + 1;
                m_pulse = 1'b1;
            end else begin
                m_tick++;
            end
        end else if (m_mode == 2) begin
            if (!pause) m_mode = 1;
        end
        if (wr_en) m_bank[wr_addr] = wr_freq;
    endtask

    // One clock: model follows the edge, new inputs go in just after it.
    task automatic cycle();
        @(posedge clk);
        #1;
        m_update();
    endtask

    task automatic wr(input int a, input int v);
        wr_en   = 1'b1;
        wr_addr = IDX_W'(a);
        wr_freq = FREQ_W'(v);
        cycle();
        wr_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("freq_out", freq_out, (m_mode == 0) ? 0 : m_bank[m_idx]);
            chk("gate", gate, (m_mode == 1) && (m_tick < int'(gate_len)) && (m_bank[m_idx] != 0));
            chk("step_idx", step_idx, m_idx);
            chk("playing", playing, m_mode != 0);
            chk("step_pulse", step_pulse, m_pulse);
        end
    end

    initial begin
        int n;
        int gcnt;
        int pcnt;
        m_reset();
        chk_en = 1'b1;
        repeat (2) cycle();
        chk("rst_freq", freq_out, 0);
        chk("rst_play", playing, 0);
        chk("rst_idx", step_idx, 0);
        chk("rst_gate", gate, 0);
        chk("rst_pulse", step_pulse, 0);
        reset = 1'b0;

        wr(0, 'h01B80);
        wr(1, 'h02000);
        wr(2, 'h00000);
        wr(3, 'h03700);
        last_step = 3;
        step_len  = 4;
        gate_len  = 2;
        start = 1'b1;
        cycle();
        start = 1'b0;
        gcnt = 0;
        pcnt = 0;
        for (int k = 0; k < 20; k++) begin
            chk("seq_idx", step_idx, (k / 4) % 4);
            chk("seq_gate", gate, ((k % 4) < 2) && (((k / 4) % 4) != 2));
            chk("seq_pulse", step_pulse, (k % 4) == 0);
            if (k == 12) chk("seq_freq3", freq_out, 'h03700);
            gcnt += int'(gate);
            pcnt += int'(step_pulse);
            cycle();
        end
        chk("seq_gate_cnt", gcnt, 8);
        chk("seq_pulse_cnt", pcnt, 5);

        repeat (2) cycle();
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("pause_idx", step_idx, 1);
            chk("pause_gate", gate, 0);
            chk("pause_play", playing, 1);
        end
        pause = 1'b0;
        cycle();
        n = 0;
        while (step_idx == 1 && n < 10) begin
            n++;
            cycle();
        end
        chk("resume_len", n, 2);

        pause = 1'b1;
        cycle();
        stop = 1'b1;
        cycle();
        stop  = 1'b0;
        pause = 1'b0;
        chk("stop_pause_idx", step_idx, 0);
        chk("stop_pause_play", playing, 0);

        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_play", playing, 0);
        cycle();
        chk("start_stop_play2", playing, 0);

        wr(4, 'h00100);
        wr(5, 'h00200);
        wr(6, 'h00300);
        wr(7, 'h00400);
        last_step = 7;
        step_len  = 0;
        gate_len  = 5;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("fast_idx", step_idx, k);
            chk("fast_gate", gate, k != 2);
            chk("fast_pulse", step_pulse, 1);
            if (k < 5) cycle();
        end
        last_step = 2;
        cycle();
        chk("last_lower_idx", step_idx, 0);

        stop = 1'b1;
        cycle();
        stop      = 1'b0;
        last_step = 3;
        step_len  = 4;
        gate_len  = 2;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        wr(1, 'h04000);
        chk("wr_cur_freq", freq_out, 'h04000);
        n = 0;
        while (step_idx == 1 && n < 10) begin
            n++;
            cycle();
        end
        chk("wr_cur_timing", n, 2);

        n = 0;
        while (step_idx != 3 && n < 50) begin
            n++;
            cycle();
        end
        chk("reach_step3", step_idx, 3);
        #1;
        reset = 1'b1;
        m_reset();
        #1;
        chk("async_freq", freq_out, 0);
        chk("async_gate", gate, 0);
        chk("async_idx", step_idx, 0);
        chk("async_play", playing, 0);
        chk("async_pulse", step_pulse, 0);
        cycle();
        reset     = 1'b0;
        last_step = 3;
        step_len  = 1;
        gate_len  = 2;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("cleared_freq", freq_out, 0);
            chk("cleared_gate", gate, 0);
            cycle();
        end

        for (int c = 0; c < 3000; c++) begin
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_addr = IDX_W'($urandom);
            wr_freq = ($urandom_range(0, 3) == 0) ? '0 : FREQ_W'($urandom);
            start   = ($urandom_range(0, 39) == 0);
            stop    = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            if ($urandom_range(0, 49) == 0) last_step = IDX_W'($urandom);
            if ($urandom_range(0, 29) == 0) gate_len = TICK_W'($urandom_range(0, 6));
            if (m_mode == 0 && !start && $urandom_range(0, 3) == 0)
                step_len = TICK_W'($urandom_range(0, 5));
            cycle();
        end
        wr_en = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cycle();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_seq_controller.md
Name: freq_seq_controller

Overview:
- Step-sequencer controller that owns a bank of STEPS frequency registers (FREQ_W bits each: integer part plus 4 fractional bits).
- Accepts writes from the control side, then plays the steps back in order at a programmable step length.
- For each step it presents the frequency word and a gate to the downstream oscillator/envelope.
- Sits between the user/keypad front-end and the tone generator.

Parameters:
- STEPS, 8, number of step registers; must be a power of two.
- FREQ_W, 20, width of one frequency word.
- TICK_W, 24, width of the step-length and gate-length counters.
- IDX_W, $clog2(STEPS), width of the step index.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for the step bank.
- wr_addr  in  IDX_W  step register to write.
- wr_freq  in  FREQ_W  frequency word to store.
- start  in  1  begin playback from step 0.
- stop  in  1  abort playback and return to IDLE.
- pause  in  1  level; high freezes playback.
- last_step  in  IDX_W  index of the final step before wrap to 0.
- step_len  in  TICK_W  clocks per step; 0 is treated as 1.
- gate_len  in  TICK_W  clocks the gate stays high at the start of each step.
- freq_out  out  FREQ_W  frequency of the current step.
- gate  out  1  note-on for the current step.
- step_idx  out  IDX_W  current step number.
- playing  out  1  high in PLAY or PAUSE.
- step_pulse  out  1  one-clock pulse on entry to each step.

Behaviour:
- Reset (asynchronous, active-high): all bank words = 0, state = IDLE, tick_cnt = 0, step_idx = 0, gate = 0, step_pulse = 0, playing = 0, freq_out = 0.
- Bank write: on a clock with wr_en = 1, bank[wr_addr] <= wr_freq. Writes are accepted in every state. A write to the current step is visible on freq_out on the next cycle.
- freq_out = bank[step_idx] in PLAY/PAUSE; 0 in IDLE. It is driven from registers only; there is no input-to-output combinational path.
- States: IDLE, PLAY, PAUSE.
- Priority within a clock: stop > start > pause.
- IDLE:
  - start -> PLAY, with step_idx = 0, tick_cnt = 0, step_pulse = 1 for the first PLAY cycle.
- PLAY:
  - tick_cnt increments each clock.
  - When tick_cnt == max(step_len,1) - 1: tick_cnt <= 0, step advances, step_pulse = 1 for the next cycle.
  - Advance rule: step_idx <= 0 if step_idx >= last_step, else step_idx + 1. This covers last_step being lowered mid-play.
  - pause = 1 -> PAUSE, with tick_cnt and step_idx frozen.
  - start while in PLAY: restart at step 0 (same as entry from IDLE).
- PAUSE:
  - Counters hold; gate = 0; step_pulse = 0.
  - pause = 0 -> PLAY, resuming at the frozen tick_cnt.
- stop in any state -> IDLE next clock: step_idx = 0, tick_cnt = 0, gate = 0.
- gate = 1 when state == PLAY, tick_cnt < gate_len, and bank[step_idx] != 0. A zero frequency word is a rest.
  - gate_len >= step_len gives legato: gate stays high across step boundaries.
  - gate_len = 0 keeps gate low.
- step_len / gate_len / last_step may change at any time; the new values take effect on the next compare.
- Timing with step_len = N: each step lasts exactly N clocks and step_pulse period = N. With N = 1, step_pulse is high every cycle.

Decomposition:
- Package freq_seq_pkg holds:
  - the state enum (IDLE, PLAY, PAUSE);
  - default STEPS, FREQ_W, TICK_W;
  - the constant FREQ_REST = 0.
- One sub-module, freq_step_bank: STEPS x FREQ_W registers with async reset, write-address decode, and a read mux on step_idx.
- The FSM and counters live in the top level.

Test Plan:
- Reset mid-play (reset asserted asynchronously while in PLAY at step 3) -> all outputs 0 immediately, before the next clock edge; bank words read back 0 after restart.
- Write steps 0..3 = 0x01B80, 0x02000, 0x00000, 0x03700; last_step = 3, step_len = 4, gate_len = 2; pulse start ->
  - step_idx sequence 0,1,2,3,0 with each step lasting 4 clocks;
  - gate high 2 of 4 clocks;
  - gate low for all of step 2 (rest);
  - step_pulse every 4 clocks.
- Pause at step 1, tick 2, held for 10 clocks -> step_idx = 1, gate = 0, playing = 1 throughout; after release, step 1 completes its remaining 2 clocks.
- start and stop on the same clock in IDLE -> stays IDLE. stop during PAUSE -> IDLE, step_idx = 0.
- step_len = 0 and gate_len = 5 -> one step per clock, gate continuously high on nonzero steps. With last_step lowered from 7 to 2 while at step 5 -> next step_idx = 0.
- Write 0x04000 to the current step during PLAY -> freq_out = 0x04000 on the following cycle, with no change to step timing.
